scan_request_assembler: RTL and testbench

- Serial-to-parallel front end for the SHA3 scanner.
- Accepts a stream of WORD_W-bit beats from the host link: WORD_COUNT block-template words, then the threshold words.
- Assembles them in a shadow buffer and issues one start pulse with the new block template and threshold, but only when the scanner is idle.
- Sits between the host command decoder and the scan request bus consumer. Replaces the purely combinational packing of pre-assembled words.

---
 rtl/sha3_scan_pkg.sv | 20 ++
 rtl/scan_request_shadow_buffer.sv | 54 +++++
 rtl/scan_request_assembler.sv | 172 +++++++++++++++++
 tb/tb_scan_request_assembler.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha3_scan_pkg.sv
// Shared constants, FSM state type and frame-length helper for the SHA3 scan
// request front end.
package sha3_scan_pkg;

    localparam int DEFAULT_WORD_W     = 32;
    localparam int DEFAULT_WORD_COUNT = 24;
    localparam int DEFAULT_THRESH_W   = 64;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        PENDING = 2'd1,
        ISSUE   = 2'd2
    } scan_state_e;

    // Beats per frame: template words followed by the threshold words.
    function automatic int calc_beats(input int word_w, input int word_count, input int thresh_w);
        return word_count + (thresh_w / word_w);
    endfunction

endpackage

// File: rtl/scan_request_shadow_buffer.sv
// Shadow storage for a frame being collected: beat-indexed template writes and
// threshold word-lane insertion (first threshold beat = least significant word).
module scan_request_shadow_buffer
    import sha3_scan_pkg::*;
#(
    parameter int WORD_W     = DEFAULT_WORD_W,
    parameter int WORD_COUNT = DEFAULT_WORD_COUNT,
    parameter int THRESH_W   = DEFAULT_THRESH_W,
    parameter int CNT_W      = 5
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [CNT_W-1:0]    wr_idx,
    input  logic [WORD_W-1:0]   wr_data,
    output logic [WORD_W-1:0]   shadow_template [WORD_COUNT],
    output logic [THRESH_W-1:0] shadow_threshold
);

    localparam int TW = THRESH_W / WORD_W;

    logic [WORD_W-1:0]   template_q [WORD_COUNT];
    logic [WORD_W-1:0]   template_d [WORD_COUNT];
    logic [THRESH_W-1:0] threshold_q;
    logic [THRESH_W-1:0] threshold_d;

    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
        template_d  = template_q;
        threshold_d = threshold_q;
        if (wr_en) begin
            for (int k = 0; k < WORD_COUNT; k++) begin
                if (wr_idx == CNT_W'(k)) begin
                    template_d[k] = wr_data;
                end
            end
            for (int j = 0; j < TW; j++) begin
                if (wr_idx == CNT_W'(WORD_COUNT + j)) begin
                    threshold_d[j*WORD_W +: WORD_W] = wr_data;
                end
            end
        end
    end

    // NOTE: shadow contents are don't-care after reset, so this storage has no reset and stays plain RAM-like flops.
    // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        template_q  <= template_d;
        threshold_q <= threshold_d;
    end

    assign shadow_template  = template_q;
    assign shadow_threshold = threshold_q;

endmodule

// File: rtl/scan_request_assembler.sv
// Serial-to-parallel scan request front end: collects a frame into a shadow buffer and
// issues it with a one-cycle start pulse once the scanner is idle. Optional macro: SCAN_REQ_COUNT_EN.
module scan_request_assembler
    import sha3_scan_pkg::*;
#(
    parameter int WORD_W     = DEFAULT_WORD_W,
    parameter int WORD_COUNT = DEFAULT_WORD_COUNT,
    parameter int THRESH_W   = DEFAULT_THRESH_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [WORD_W-1:0]   in_data,
    output logic                in_ready,
    input  logic                abort,
    input  logic                scan_busy,
    output logic                start,
    output logic [WORD_W-1:0]   block_template [WORD_COUNT],
    output logic [THRESH_W-1:0] threshold,
    output logic                frame_pending
`ifdef SCAN_REQ_COUNT_EN
    ,
    output logic [15:0]         req_count
`endif
);

    localparam int TW    = THRESH_W / WORD_W;
    localparam int BEATS = calc_beats(WORD_W, WORD_COUNT, THRESH_W);
    localparam int CNT_W = $clog2(BEATS + 1);

    if (TW * WORD_W != THRESH_W) begin : g_bad_thresh_w
        $error("scan_request_assembler: THRESH_W must be a non-zero multiple of WORD_W");
    end
    if (BEATS < 2) begin : g_bad_beats
        $error("scan_request_assembler: a frame needs at least two beats");
    end

    scan_state_e         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                start_q, start_d;
    logic                frame_pending_q, frame_pending_d;
    logic [WORD_W-1:0]   template_q [WORD_COUNT];
    logic [WORD_W-1:0]   template_d [WORD_COUNT];
    logic [THRESH_W-1:0] threshold_q, threshold_d;

    logic                beat_accept;
    logic                shadow_wr_en;
    logic                load_active;
    logic [WORD_W-1:0]   shadow_template [WORD_COUNT];
    logic [THRESH_W-1:0] shadow_threshold;

    assign in_ready     = (state_q == COLLECT);
    assign beat_accept  = in_valid && in_ready;
    // Abort wins over a beat accepted in the same cycle: the beat is never stored.
    assign shadow_wr_en = beat_accept && !abort;

    scan_request_shadow_buffer #(
        .WORD_W     (WORD_W),
        .WORD_COUNT (WORD_COUNT),
        .THRESH_W   (THRESH_W),
        .CNT_W      (CNT_W)
    ) u_shadow (
        .clk              (clk),
        .wr_en            (shadow_wr_en),
        .wr_idx           (cnt_q),
        .wr_data          (in_data),
        .shadow_template  (shadow_template),
        .shadow_threshold (shadow_threshold)
    );

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        start_d         = 1'b0;
        frame_pending_d = frame_pending_q;
        load_active     = 1'b0;
        unique case (state_q)
            COLLECT: begin
                if (abort) begin
                    cnt_d = '0;
                end else if (beat_accept) begin
                    if (cnt_q == CNT_W'(BEATS - 1)) begin
                        cnt_d           = '0;
                        state_d         = PENDING;
                        frame_pending_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            PENDING: begin
                if (abort) begin
                    state_d         = COLLECT;
                    frame_pending_d = 1'b0;
                end else if (!scan_busy) begin
                    state_d         = ISSUE;
                    start_d         = 1'b1;
                    frame_pending_d = 1'b0;
                    load_active     = 1'b1;
                end
            end
            ISSUE: begin
                // Abort is deliberately ignored here; the issue always completes.
                state_d = COLLECT;
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_comb begin
        template_d  = template_q;
        threshold_d = threshold_q;
        if (load_active) begin
            template_d  = shadow_template;
            threshold_d = shadow_threshold;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= COLLECT;
            cnt_q           <= '0;
            start_q         <= 1'b0;
            frame_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            start_q         <= start_d;
            frame_pending_q <= frame_pending_d;
        end
    end

    // Active request registers: only ever written on the ISSUE entry edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            template_q  <= '{default: '0};
            threshold_q <= '0;
        end else begin
            template_q  <= template_d;
            threshold_q <= threshold_d;
        end
    end

    assign start          = start_q;
    assign frame_pending  = frame_pending_q;
    assign block_template = template_q;
    assign threshold      = threshold_q;

`ifdef SCAN_REQ_COUNT_EN
    logic [15:0] req_count_q, req_count_d;

    always_comb begin
        req_count_d = req_count_q;
        if (load_active) begin
            req_count_d = req_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_count_q <= '0;
        end else begin
            req_count_q <= req_count_d;
        end
    end

    assign req_count = req_count_q;
`endif

endmodule

// File: tb/tb_scan_request_assembler.sv
// Self-checking bench for scan_request_assembler: table-driven nominal frame, hand-written
// corner sequences and a randomized run against a queue-based frame model.
module tb_scan_request_assembler;

    localparam int WORD_W     = 32;
    localparam int WORD_COUNT = 24;
    localparam int THRESH_W   = 64;
    localparam int BEATS      = 26;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic [WORD_W-1:0]   in_data;
    logic                in_ready;
    logic                abort;
    logic                scan_busy;
    logic                start;
    logic [WORD_W-1:0]   block_template [WORD_COUNT];
    logic [THRESH_W-1:0] threshold;
    logic                frame_pending;
`ifdef SCAN_REQ_COUNT_EN
    logic [15:0]         req_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    scan_request_assembler #(
        .WORD_W     (WORD_W),
        .WORD_COUNT (WORD_COUNT),
        .THRESH_W   (THRESH_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .abort          (abort),
        .scan_busy      (scan_busy),
        .start          (start),
        .block_template (block_template),
        .threshold      (threshold),
        .frame_pending  (frame_pending)
`ifdef SCAN_REQ_COUNT_EN
        ,
        .req_count      (req_count)
`endif
    );

    // Reference model: beats of the current frame in a queue, plus "waiting" and "issuing" flags.
    logic [WORD_W-1:0]   m_words [$];
    bit                  m_pending;
    bit                  m_issue;
    logic [WORD_W-1:0]   m_tmpl [WORD_COUNT];
    logic [THRESH_W-1:0] m_thr;
    int unsigned         m_count;

    logic [WORD_W-1:0]   fb [BEATS];

    typedef struct {
        bit                v;
        logic [WORD_W-1:0] d;
        bit                ab;
        bit                busy;
        bit                e_ready;
        bit                e_start;
        bit                e_pend;
    } vec_t;
    vec_t tbl [30];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_words.delete();
        m_pending = 1'b0;
        m_issue   = 1'b0;
        foreach (m_tmpl[k]) m_tmpl[k] = '0;
        m_thr   = '0;
        m_count = 0;
    endfunction

    function automatic void model_edge();
        if (m_issue) begin
            m_issue = 1'b0;
        end else if (m_pending) begin
            if (abort) begin
                m_pending = 1'b0;
                m_words.delete();
            end else if (!scan_busy) begin
                m_pending = 1'b0;
                m_issue   = 1'b1;
                for (int k = 0; k < WORD_COUNT; k++) m_tmpl[k] = m_words[k];
                m_thr = {m_words[WORD_COUNT+1], m_words[WORD_COUNT]};
                m_words.delete();
                m_count++;
            end
        end else begin
            if (abort) begin
                m_words.delete();
            end else if (in_valid) begin
                m_words.push_back(in_data);
                if (m_words.size() == BEATS) m_pending = 1'b1;
            end
        end
    endfunction

    task automatic compare_model();
        check("in_ready", in_ready, !(m_pending || m_issue));
        check("start", start, m_issue);
        check("frame_pending", frame_pending, m_pending);
        check("threshold", threshold, m_thr);
        for (int k = 0; k < WORD_COUNT; k++)
            check($sformatf("block_template[%0d]", k), block_template[k], m_tmpl[k]);
`ifdef SCAN_REQ_COUNT_EN
        check("req_count", req_count, m_count[15:0]);
`endif
    endtask

    // One clock: drive at the falling edge, let the model see the rising edge, compare 2ns later.
    task automatic cycle(input bit v, input logic [WORD_W-1:0] d, input bit ab, input bit busy);
        in_valid  = v;
        in_data   = d;
        abort     = ab;
        scan_busy = busy;
        @(posedge clk);
        model_edge();
        #2;
        compare_model();
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit busy);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, busy);
    endtask

    // Sends fb[first..last] in order; gap_pct is the chance of an idle cycle before each beat.
    task automatic send_beats(input int first, input int last, input bit busy, input int gap_pct);
        int idx = first;
        int guard = 0;
        while (idx <= last && guard < 2000) begin
            guard++;
            if (int'($urandom_range(99)) < gap_pct) begin
                cycle(1'b0, $urandom, 1'b0, busy);
            end else begin
                cycle(1'b1, fb[idx], 1'b0, busy);
                idx++;
            end
        end
        check("send_beats_done", idx, last + 1);
    endtask

    task automatic fill_fb(input logic [WORD_W-1:0] base);
        for (int k = 0; k < BEATS; k++) fb[k] = base + WORD_W'(k);
    endtask

    task automatic apply_reset_checked();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_start", start, 1'b0);
        check("rst_frame_pending", frame_pending, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_threshold", threshold, '0);
        for (int k = 0; k < WORD_COUNT; k++)
            check($sformatf("rst_template[%0d]", k), block_template[k], '0);
`ifdef SCAN_REQ_COUNT_EN
        check("rst_req_count", req_count, '0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        abort     = 1'b0;
        scan_busy = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        apply_reset_checked();

        // Nominal frame as a table of per-cycle inputs and expected control outputs.
        for (int k = 0; k < WORD_COUNT; k++) tbl[k] = '{1'b1, 32'h100 + k, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[24] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[25] = '{1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[26] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[27] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[28] = '{1'b1, 32'h55,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[29] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 30; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].ab, tbl[i].busy);
            check($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_ready);
            check($sformatf("tbl%0d_start", i), start, tbl[i].e_start);
            check($sformatf("tbl%0d_frame_pending", i), frame_pending, tbl[i].e_pend);
        end
        for (int k = 0; k < WORD_COUNT; k++)
            check($sformatf("nominal_template[%0d]", k), block_template[k], 32'h100 + k);
        check("nominal_threshold", threshold, 64'h0000_0001_FFFF_FFFF);

        // Busy hold: frame completes while the scanner is busy for 50 cycles.
        fill_fb(32'hA000);
        send_beats(0, BEATS - 1, 1'b1, 0);
        idle(50, 1'b1);
        check("hold_template0", block_template[0], 32'h100);
        check("hold_frame_pending", frame_pending, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0);
        check("busy_release_start", start, 1'b1);
        check("busy_release_template5", block_template[5], 32'hA005);
        idle(1, 1'b1);
        idle(2, 1'b0);

        // Abort with beat 10 of frame A, then a complete frame B.
        fill_fb(32'hB000);
        send_beats(0, 9, 1'b0, 0);
        cycle(1'b1, fb[10], 1'b1, 1'b0);
        fill_fb(32'hC000);
        send_beats(0, BEATS - 1, 1'b0, 0);
        idle(3, 1'b0);
        check("abort_b_template10", block_template[10], 32'hC00A);
        check("abort_b_threshold", threshold, {32'hC019, 32'hC018});

        // Abort while pending: no start, frame dropped, outputs keep frame B.
        fill_fb(32'hD000);
        send_beats(0, BEATS - 1, 1'b0, 0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("pend_abort_frame_pending", frame_pending, 1'b0);
        idle(3, 1'b0);
        check("pend_abort_template0", block_template[0], 32'hC000);

        // Gapped input reproduces the nominal frame.
        for (int k = 0; k < WORD_COUNT; k++) fb[k] = 32'h100 + k;
        fb[24] = 32'hFFFF_FFFF;
        fb[25] = 32'h0000_0001;
        send_beats(0, BEATS - 1, 1'b0, 50);
        idle(3, 1'b0);
        for (int k = 0; k < WORD_COUNT; k++)
            check($sformatf("gapped_template[%0d]", k), block_template[k], 32'h100 + k);
        check("gapped_threshold", threshold, 64'h0000_0001_FFFF_FFFF);

        // Reset after beat 5, then a full frame.
        fill_fb(32'hE000);
        send_beats(0, 5, 1'b0, 0);
        apply_reset_checked();
        fill_fb(32'hF000);
        send_beats(0, BEATS - 1, 1'b0, 0);
        idle(3, 1'b0);
        check("post_reset_template23", block_template[23], 32'hF017);

        // Reset while start is high forces it low at once.
        fill_fb(32'h1234_0000);
        send_beats(0, BEATS - 1, 1'b0, 0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        check("pre_reset_start", start, 1'b1);
        apply_reset_checked();

`ifdef SCAN_REQ_COUNT_EN
        for (int f = 0; f < 3; f++) begin
            fill_fb(32'h7000 + 32'(f * 256));
            send_beats(0, BEATS - 1, 1'b0, 0);
            idle(3, 1'b0);
        end
        check("req_count_three", req_count, 16'd3);
        force dut.req_count_q = 16'hFFFF;
        #1;
        release dut.req_count_q;
        m_count = 32'hFFFF;
        send_beats(0, BEATS - 1, 1'b0, 0);
        idle(3, 1'b0);
        check("req_count_wrap", req_count, 16'h0000);
`endif

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(1)), $urandom, $urandom_range(99) == 0,
                  $urandom_range(3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
